// File: rtl/test_run_supervisor.sv
// Run supervisor: staggered per-channel DUT reset release, run-cycle timing and a single terminal verdict.
// Outputs registered, verdict one cycle after the deciding sample, no backpressure; heartbeat via TEST_RUN_SUPERVISOR_HEARTBEAT_EN.
module test_run_supervisor #(
  parameter int NUM_CH   = 4,
  parameter int CYCLE_W  = 64,
  parameter int RST_HOLD = 16,
  parameter int STAGGER  = 4,
  parameter int HB_LOG2  = 10,
  localparam int FAIL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_pass_mode,
  input  logic [CYCLE_W-1:0] i_max_cycles,
  input  logic [NUM_CH-1:0]  i_ch_success,
  input  logic [NUM_CH-1:0]  i_ch_failure,
  output logic [NUM_CH-1:0]  o_dut_reset_n,
  output logic [CYCLE_W-1:0] o_cycle_count,
  output logic [2:0]         o_status,
  output logic               o_done,
  output logic               o_passed,
  output logic [FAIL_W-1:0]  o_fail_ch,
  output logic               o_heartbeat
);
  localparam int LAST_REL = RST_HOLD + (NUM_CH - 1) * STAGGER;
  localparam int CNT_W    = $clog2(LAST_REL + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESETTING = 3'd1,
    S_RUN       = 3'd2,
    S_PASS      = 3'd3,
    S_FAIL      = 3'd4,
    S_TIMEOUT   = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_rst_cnt, w_rst_cnt_nxt;
  logic [NUM_CH-1:0]  r_dut_rst_n, w_dut_rst_nxt;
  logic [NUM_CH-1:0]  r_sticky, w_sticky_nxt, w_seen;
  logic [CYCLE_W-1:0] r_cycles, w_cycles_nxt, w_cycles_inc;
  logic [CYCLE_W-1:0] r_max_cycles, w_max_nxt;
  logic [FAIL_W-1:0]  r_fail_ch, w_fail_ch_nxt, w_first_fail;
  logic               r_done, w_done_nxt, r_passed, w_passed_nxt;
  logic               r_pass_mode, w_mode_nxt, w_pass_hit;

  assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + 1'b1;
  assign w_seen       = r_sticky | i_ch_success;
  assign w_pass_hit   = r_pass_mode ? (|w_seen) : (&w_seen);

  always_comb begin : first_fail
    w_first_fail = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (i_ch_failure[i]) w_first_fail = FAIL_W'(i);
  end

  always_comb begin : next_state
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_dut_rst_nxt = r_dut_rst_n;
    w_sticky_nxt  = r_sticky;
    w_cycles_nxt  = r_cycles;
    w_max_nxt     = r_max_cycles;
    w_fail_ch_nxt = r_fail_ch;
    w_done_nxt    = r_done;
    w_passed_nxt  = r_passed;
    w_mode_nxt    = r_pass_mode;
    case (r_state)
      S_RESETTING: begin
        if (r_rst_cnt == CNT_W'(LAST_REL)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 1'b1;
          // released bits only ever set, so staggered channels stay out of reset
          for (int i = 0; i < NUM_CH; i++)
            if (w_rst_cnt_nxt >= CNT_W'(RST_HOLD + i * STAGGER)) w_dut_rst_nxt[i] = 1'b1;
        end
      end
      S_RUN: begin
        w_cycles_nxt = w_cycles_inc;
        w_sticky_nxt = w_seen;
        if (|i_ch_failure) begin
          w_state_nxt   = S_FAIL;
          w_fail_ch_nxt = w_first_fail;
          w_done_nxt    = 1'b1;
        end else if (w_pass_hit) begin
          w_state_nxt  = S_PASS;
          w_done_nxt   = 1'b1;
          w_passed_nxt = 1'b1;
        end else if ((r_max_cycles != '0) && (w_cycles_inc == r_max_cycles)) begin
          w_state_nxt = S_TIMEOUT;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        // idle and terminal states: only a start pulse moves us
        if (i_start) begin
          w_state_nxt   = S_RESETTING;
          w_rst_cnt_nxt = '0;
          w_dut_rst_nxt = '0;
          w_sticky_nxt  = '0;
          w_cycles_nxt  = '0;
          w_fail_ch_nxt = '0;
          w_done_nxt    = 1'b0;
          w_passed_nxt  = 1'b0;
          w_mode_nxt    = i_pass_mode;
          w_max_nxt     = i_max_cycles;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_dut_rst_n  <= '0;
      r_sticky     <= '0;
      r_cycles     <= '0;
      r_max_cycles <= '0;
      r_fail_ch    <= '0;
      r_done       <= 1'b0;
      r_passed     <= 1'b0;
      r_pass_mode  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_dut_rst_n  <= w_dut_rst_nxt;
      r_sticky     <= w_sticky_nxt;
      r_cycles     <= w_cycles_nxt;
      r_max_cycles <= w_max_nxt;
      r_fail_ch    <= w_fail_ch_nxt;
      r_done       <= w_done_nxt;
      r_passed     <= w_passed_nxt;
      r_pass_mode  <= w_mode_nxt;
    end
  end

`ifdef TEST_RUN_SUPERVISOR_HEARTBEAT_EN
  logic r_heartbeat, w_hb_nxt;

  // pulse only while the run continues and the counter really advanced onto a period boundary
  assign w_hb_nxt = (r_state == S_RUN) && (w_state_nxt == S_RUN) && !(&r_cycles) &&
                    (w_cycles_inc[HB_LOG2-1:0] == '0);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_heartbeat <= 1'b0;
    else            r_heartbeat <= w_hb_nxt;
  end

  assign o_heartbeat = r_heartbeat;
`else
  // constant low; HB_LOG2 only shapes the heartbeat build
  assign o_heartbeat = (HB_LOG2 < 0);
`endif

  assign o_dut_reset_n = r_dut_rst_n;
  assign o_cycle_count = r_cycles;
  assign o_status      = r_state;
  assign o_done        = r_done;
  assign o_passed      = r_passed;
  assign o_fail_ch     = r_fail_ch;
endmodule

// File: tb/tb_test_run_supervisor.sv
// Bench for test_run_supervisor: random and directed runs, verdicts checked by a scoreboard monitor.
module tb_test_run_supervisor;
  localparam int NCH  = 4;
  localparam int CW   = 64;
  localparam int RH   = 16;
  localparam int ST   = 4;
  localparam int HBL  = 4;
  localparam int LAST = RH + (NCH - 1) * ST;
`ifdef TEST_RUN_SUPERVISOR_HEARTBEAT_EN
  localparam bit HB_EN = 1'b1;
`else
  localparam bit HB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b1;
  logic          i_start = 1'b0;
  logic          i_pass_mode = 1'b0;
  logic [CW-1:0] i_max_cycles = '0;
  logic [NCH-1:0] i_ch_success = '0;
  logic [NCH-1:0] i_ch_failure = '0;
  logic [NCH-1:0] o_dut_reset_n;
  logic [CW-1:0] o_cycle_count;
  logic [2:0]    o_status;
  logic          o_done, o_passed, o_heartbeat;
  logic [1:0]    o_fail_ch;

  test_run_supervisor #(
    .NUM_CH(NCH), .CYCLE_W(CW), .RST_HOLD(RH), .STAGGER(ST), .HB_LOG2(HBL)
  ) dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_pass_mode(i_pass_mode),
    .i_max_cycles(i_max_cycles), .i_ch_success(i_ch_success), .i_ch_failure(i_ch_failure),
    .o_dut_reset_n(o_dut_reset_n), .o_cycle_count(o_cycle_count), .o_status(o_status),
    .o_done(o_done), .o_passed(o_passed), .o_fail_ch(o_fail_ch), .o_heartbeat(o_heartbeat)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int t; } rel_t;
  typedef struct {
    logic [2:0]  status;
    logic        passed;
    logic [1:0]  fail_ch;
    logic [63:0] count;
    int          nrun;
  } verdict_t;

  int       n_tests = 0;
  int       n_fail  = 0;
  rel_t     q_rel[$];
  int       q_run[$];
  verdict_t q_verdict[$];
  bit [3:0] sched_s[$];
  bit [3:0] sched_f[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: walk the run cycle by cycle applying the verdict rules to the schedule.
  function automatic void model(input bit mode, input logic [63:0] maxc, output verdict_t v);
    bit [3:0] seen = 4'h0;
    bit [3:0] s, f;
    v.status = 3'd7; v.passed = 1'b0; v.fail_ch = 2'd0; v.count = 64'd0; v.nrun = 5000;
    for (int k = 0; k < 5000; k++) begin
      s = (k < sched_s.size()) ? sched_s[k] : 4'h0;
      f = (k < sched_f.size()) ? sched_f[k] : 4'h0;
      if (f != 4'h0) begin
        v.status = 3'd4;
        for (int i = 3; i >= 0; i--) if (f[i]) v.fail_ch = 2'(i);
      end else begin
        seen |= s;
        if (mode ? (seen != 4'h0) : (seen == 4'hF)) begin
          v.status = 3'd3;
          v.passed = 1'b1;
        end else if (maxc != 64'd0 && 64'(k + 1) == maxc) begin
          v.status = 3'd5;
        end
      end
      if (v.status != 3'd7) begin
        v.count = 64'(k + 1);
        v.nrun  = k + 1;
        return;
      end
    end
  endfunction

  // Monitor: reset-release timing, per-cycle run counter/heartbeat, verdict scoreboard, freeze.
  logic [2:0] pst = 3'd0;
  logic [3:0] pdut = 4'h0;
  logic       pdone = 1'b0;
  bit         in_rs = 1'b0, in_run = 1'b0, cur_ok = 1'b0;
  int         t_rs = 0, run_t = 0, er;
  verdict_t   cur;
  rel_t       rr;
  logic [3:0] newb;
  logic       exp_hb;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (o_status == 3'd0) begin in_rs = 1'b0; in_run = 1'b0; cur_ok = 1'b0; end
      if (o_status == 3'd1 && pst != 3'd1) begin
        in_rs = 1'b1; t_rs = 0; cur_ok = 1'b0;
        chk("start_dut_rst", 64'(o_dut_reset_n), 64'h0);
        chk("start_count", o_cycle_count, 64'h0);
        chk("start_done", 64'(o_done), 64'h0);
        chk("start_passed", 64'(o_passed), 64'h0);
        chk("start_fail_ch", 64'(o_fail_ch), 64'h0);
      end else if (in_rs) t_rs++;
      if (in_rs) begin
        newb = o_dut_reset_n & ~pdut;
        for (int i = 0; i < NCH; i++) if (newb[i]) begin
          if (q_rel.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rel_unexpected: channel %0d released at %0d, none expected", i, t_rs);
          end else begin
            rr = q_rel.pop_front();
            chk("rel_ch", 64'(i), 64'(rr.ch));
            chk("rel_time", 64'(t_rs), 64'(rr.t));
          end
        end
      end
      if (in_rs && o_status == 3'd2) begin
        in_rs = 1'b0; in_run = 1'b1; run_t = 0;
        er = (q_run.size() != 0) ? q_run.pop_front() : -1;
        chk("run_entry_time", 64'(t_rs), 64'(er));
        chk("rel_pending", 64'(q_rel.size()), 64'h0);
        chk("run_dut_rst", 64'(o_dut_reset_n), 64'hF);
      end else if (in_run) run_t++;
      exp_hb = HB_EN && in_run && o_status == 3'd2 && run_t > 0 && (run_t % (1 << HBL)) == 0;
      chk("heartbeat", 64'(o_heartbeat), 64'(exp_hb));
      if (in_run && o_status == 3'd2) chk("run_count", o_cycle_count, 64'(run_t));
      if (o_done && !pdone) begin
        if (q_verdict.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL verdict_unexpected: status %0d with no verdict expected", o_status);
        end else begin
          cur = q_verdict.pop_front(); cur_ok = 1'b1;
          chk("v_status", 64'(o_status), 64'(cur.status));
          chk("v_passed", 64'(o_passed), 64'(cur.passed));
          chk("v_fail_ch", 64'(o_fail_ch), 64'(cur.fail_ch));
          chk("v_count", o_cycle_count, cur.count);
          chk("v_latency", 64'(run_t), 64'(cur.nrun));
        end
        in_run = 1'b0;
      end else if (o_done && cur_ok) begin
        chk("frz_status", 64'(o_status), 64'(cur.status));
        chk("frz_count", o_cycle_count, cur.count);
        chk("frz_passed", 64'(o_passed), 64'(cur.passed));
        chk("frz_fail_ch", 64'(o_fail_ch), 64'(cur.fail_ch));
        chk("frz_dut_rst", 64'(o_dut_reset_n), 64'hF);
      end
      pst = o_status; pdut = o_dut_reset_n; pdone = o_done;
    end
  end

  task automatic run_one(input bit mode, input logic [63:0] maxc, input bit abort);
    verdict_t v;
    rel_t     r;
    int       nr;
    model(mode, maxc, v);
    for (int i = 0; i < NCH; i++) begin r.ch = i; r.t = RH + i * ST; q_rel.push_back(r); end
    q_run.push_back(LAST + 1);
    if (!abort) q_verdict.push_back(v);
    @(negedge clk);
    i_start = 1'b1; i_pass_mode = mode; i_max_cycles = maxc;
    i_ch_success = 4'($urandom); i_ch_failure = 4'($urandom);
    @(posedge clk); #1;
    i_start = 1'b0; i_pass_mode = ~mode; i_max_cycles = {$urandom, $urandom};
    for (int c = 1; c <= LAST + 1; c++) begin
      i_ch_success = 4'($urandom); i_ch_failure = 4'($urandom); i_start = (c == 5);
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    nr = abort ? 37 : v.nrun;
    for (int k = 0; k < nr; k++) begin
      i_ch_success = (!abort && k < sched_s.size()) ? sched_s[k] : 4'h0;
      i_ch_failure = (!abort && k < sched_f.size()) ? sched_f[k] : 4'h0;
      i_start = (k == nr / 2); i_pass_mode = 1'($urandom);
      @(posedge clk); #1;
    end
    i_start = 1'b0; i_ch_success = '0; i_ch_failure = '0;
    if (abort) begin
      chk("abort_count", o_cycle_count, 64'd37);
      i_reset_n = 1'b0; #1;
      chk("abort_dut_rst", 64'(o_dut_reset_n), 64'h0);
      chk("abort_count0", o_cycle_count, 64'h0);
      chk("abort_status", 64'(o_status), 64'h0);
      chk("abort_done", 64'(o_done), 64'h0);
      chk("abort_passed", 64'(o_passed), 64'h0);
      chk("abort_fail_ch", 64'(o_fail_ch), 64'h0);
      chk("abort_hb", 64'(o_heartbeat), 64'h0);
      repeat (2) @(negedge clk);
      i_reset_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c < 4; c++) begin
        i_ch_success = 4'($urandom); i_ch_failure = 4'($urandom);
        @(posedge clk); #1;
      end
      i_ch_success = '0; i_ch_failure = '0;
      for (int w = 0; w < 20 && q_verdict.size() != 0; w++) @(posedge clk);
      chk("verdict_pending", 64'(q_verdict.size()), 64'h0);
    end
    chk("rel_left", 64'(q_rel.size()), 64'h0);
    q_verdict.delete(); q_rel.delete(); q_run.delete();
  endtask

  task automatic gen_random();
    sched_s.delete(); sched_f.delete();
    for (int k = 0; k < 200; k++) begin
      sched_s.push_back(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      sched_f.push_back(($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
    end
    sched_s[199] = 4'hF; sched_f[199] = 4'h0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin : stimulus
    #2 i_reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_dut_rst", 64'(o_dut_reset_n), 64'h0);
    chk("rst_count", o_cycle_count, 64'h0);
    chk("rst_status", 64'(o_status), 64'h0);
    chk("rst_done", 64'(o_done), 64'h0);
    chk("rst_passed", 64'(o_passed), 64'h0);
    chk("rst_fail_ch", 64'(o_fail_ch), 64'h0);
    chk("rst_hb", 64'(o_heartbeat), 64'h0);
    @(negedge clk); i_reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_ch_success = 4'($urandom); i_ch_failure = 4'($urandom);
      @(posedge clk); #1;
    end
    chk("idle_status", 64'(o_status), 64'h0);
    chk("idle_dut_rst", 64'(o_dut_reset_n), 64'h0);

    sched_s = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8}; sched_f = '{};
    run_one(1'b0, 64'd0, 1'b0);
    sched_s = '{4'h0, 4'h0, 4'h0, 4'hF}; sched_f = '{4'h0, 4'h0, 4'h0, 4'h4};
    run_one(1'b0, 64'd0, 1'b0);
    sched_s = '{4'hF}; sched_f = '{4'hA};
    run_one(1'b1, 64'd0, 1'b0);
    sched_s = '{}; sched_f = '{};
    run_one(1'b0, 64'd100, 1'b0);
    sched_s = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF}; sched_f = '{};
    run_one(1'b0, 64'd5, 1'b0);
    sched_s = '{4'h0, 4'h0, 4'hF}; sched_f = '{4'h0, 4'h0, 4'h8};
    run_one(1'b1, 64'd3, 1'b0);
    sched_s = '{}; sched_f = '{};
    for (int k = 0; k < 10; k++) sched_s.push_back(4'h0);
    sched_s.push_back(4'h4);
    run_one(1'b1, 64'd0, 1'b0);
    sched_s = '{4'h3, 4'h0, 4'h4}; sched_f = '{};
    run_one(1'b0, 64'd8, 1'b0);
    sched_s = '{}; sched_f = '{};
    run_one(1'b0, 64'd1, 1'b0);
    sched_s = '{}; sched_f = '{};
    for (int k = 0; k < 49; k++) sched_s.push_back(4'h0);
    sched_s.push_back(4'hF);
    run_one(1'b0, 64'd0, 1'b0);
    sched_s = '{}; sched_f = '{};
    run_one(1'b0, 64'd0, 1'b1);
    sched_s = '{4'h8, 4'h4, 4'h2, 4'h1}; sched_f = '{};
    run_one(1'b0, 64'd0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      gen_random();
      run_one(1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(1, 80)), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
